bpsk_word_collector: RTL

Parametrised deserialiser behind the BPSK bit demodulator in the comm receive path. It packs single-bit demodulated symbols into WORD_W-bit words, in a configurable bit order, with frame realignment on start-of-frame. It applies a ready/valid handshake toward the word consumer, with overflow detection and an idle timeout that discards stalled partial words.

---
 rtl/bpsk_word_collector.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bpsk_word_collector.sv
// BPSK bit-to-word deserialiser with ready/valid output, overflow and idle timeout.
// Optional trailing even-parity bit per word when COLLECT_PARITY_EN is defined.
module bpsk_word_collector #(
   parameter int WORD_W    = 32,
   parameter int MSB_FIRST = 0,
   parameter int TIMEOUT   = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              valid_i,
   input  logic              data_i,
   input  logic              sof_i,
   input  logic              ready_i,
   input  logic              clr_ovf_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] data_o,
   output logic              overflow_o,
   output logic              abort_o,
   output logic              parity_err_o
);

`ifdef COLLECT_PARITY_EN
   localparam int NB = WORD_W + 1;
`else
   localparam int NB = WORD_W;
`endif
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WORD_W-1:0] sr_q, sr_d, sr_shift, word;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idle_q, idle_d;
   logic              valid_q, valid_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              abort_q, abort_d;
   logic              complete, slot_free;
   logic              perr_word;

   always_comb begin
      if (MSB_FIRST != 0)
         sr_shift = {sr_q[WORD_W-2:0], data_i};
      else
         sr_shift = {data_i, sr_q[WORD_W-1:1]};
   end

`ifdef COLLECT_PARITY_EN
   // the final bit of a word is the parity bit; data is already in sr_q
   assign word      = sr_q;
   assign perr_word = ^{sr_q, data_i};
`else
   assign word      = sr_shift;
   assign perr_word = 1'b0;
`endif

   assign complete  = valid_i &&
                      (sof_i ? (NB == 1) : (cnt_q == CW'(NB - 1)));
   assign slot_free = !valid_q || ready_i;

   always_comb begin
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      abort_d = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      if (valid_i) begin
         sr_d   = sr_shift;
         idle_d = '0;
         if (sof_i) begin
            cnt_d   = complete ? '0 : CW'(1);
            abort_d = (cnt_q != '0);
         end else begin
            cnt_d = complete ? '0 : cnt_q + CW'(1);
         end
      end else if (TIMEOUT > 0 && cnt_q != '0) begin
         if (idle_q == IW'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            idle_d  = '0;
            abort_d = 1'b1;
         end else begin
            idle_d = idle_q + IW'(1);
         end
      end else begin
         idle_d = '0;
      end
      if (clr_ovf_i)
         ovf_d = 1'b0;
      // a drop in the same cycle as a clear leaves overflow set
      if (complete && slot_free) begin
         valid_d = 1'b1;
         data_d  = word;
      end else if (complete) begin
         ovf_d = 1'b1;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         idle_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         abort_q <= abort_d;
      end
   end

`ifdef COLLECT_PARITY_EN
   logic perr_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         perr_q <= 1'b0;
      else if (complete && slot_free)
         perr_q <= perr_word;
   end

   assign parity_err_o = perr_q;
`else
   assign parity_err_o = perr_word;
`endif

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign overflow_o = ovf_q;
   assign abort_o    = abort_q;

endmodule
